uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
- Host-side controller for the uart peripheral core: the other end of its write/tx_ready/rx_new/read handshake.
- Buffers CPU-written bytes in a TX FIFO and feeds them to the core one at a time.
- Drains bytes the core received into an RX FIFO.
- Sits between the CPU I/O bus decode and the uart instance; all logic runs on the CPU clock.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries each)

Ports:
clk  input  1  system clock, same clock as the uart core
rst  input  1  synchronous active-high reset
cpu_wr_en  input  1  one-cycle strobe; push cpu_wr_data into TX FIFO
cpu_wr_data  input  8  byte to transmit
cpu_rd_en  input  1  one-cycle strobe; pop RX FIFO head
cpu_rd_data  output  8  RX FIFO head, valid when rx_empty=0
tx_full  output  1  TX FIFO full
tx_empty  output  1  TX FIFO empty and no byte in flight
rx_empty  output  1  RX FIFO empty
rx_overrun  output  1  sticky; a received byte was dropped
ovr_clr  input  1  clears rx_overrun
uart_tx_data  output  8  to core tx_data_in
uart_write  output  1  to core write; rising edge starts transmission
uart_tx_ready  input  1  from core tx_ready
uart_rx_data  input  8  from core rx_data_out
uart_rx_new  input  1  from core rx_new
uart_read  output  1  to core read; rising edge clears rx_new

Behaviour:
- Reset (synchronous, rst=1 at posedge clk): both FIFOs emptied, both FSMs to IDLE.
  - uart_write=0, uart_read=0, uart_tx_data=0, rx_overrun=0.
  - tx_full=0, tx_empty=1, rx_empty=1, cpu_rd_data=0.
- Reset mid-transmission abandons the in-flight byte on the host side. The core still finishes it; the TX FSM re-syncs by waiting for uart_tx_ready=1 in IDLE.
- All outputs are registered; the core edge-detects write/read against registered prev values.
- FIFOs: circular, DEPTH_LOG2+1-bit pointers; full/empty from MSB compare.
  - Push when full: ignored, no state change.
  - Pop when empty: ignored.
  - Simultaneous push and pop on the same FIFO in one cycle are both honoured, including when full (pop frees a slot) and when empty (RX only: head appears next cycle).
  - cpu_rd_data is the registered head; it updates the cycle after a pop or after a push into an empty FIFO.
- TX FSM (IDLE, STROBE, WAIT_BUSY, WAIT_DONE):
  - IDLE: if TX FIFO not empty and uart_tx_ready=1, load uart_tx_data from head, pop, set uart_write=1, go to STROBE.
  - STROBE: hold uart_write=1 and uart_tx_data stable for this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: uart_write=0; stay until uart_tx_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until uart_tx_ready=1, then go to IDLE.
  - Minimum gap between successive uart_write rising edges is 4 clk plus the core's transmit time.
  - tx_empty=1 only when the FIFO is empty and the FSM is in IDLE.
- RX FSM (IDLE, ACK, GAP), fixed 3-cycle accept:
  - IDLE: if uart_rx_new=1, push uart_rx_data into RX FIFO. If the FIFO is full (and no same-cycle cpu pop), drop the byte and set rx_overrun=1. Set uart_read=1, go to ACK.
  - ACK: uart_read=0, go to GAP.
  - GAP: go to IDLE. This lets the core's rx_new clear propagate; rx_new is never sampled in ACK or GAP.
  - A byte arriving in the same cycle the core clears rx_new leaves rx_new=1 and is accepted on the next IDLE pass. No loss and no duplicate.
- rx_overrun: set by a drop, cleared by ovr_clr. Set has priority over a same-cycle clear.
- cpu_wr_en and cpu_rd_en are level-sampled every clock; each high cycle is one operation.

Optional Feature:
UART_HOST_IRQ_EN
- Defined: adds output irq (1 bit, registered, reset 0).
  - irq = (!rx_empty) | rx_overrun | tx_empty_rise_sticky.
  - tx_empty_rise_sticky is set when tx_empty goes 0->1 and cleared by cpu_wr_en.
- Not defined: no irq port, no sticky register. All other behaviour is identical.

Test Plan:
- Reset then idle, uart_tx_ready=1 -> uart_write=0, tx_empty=1, rx_empty=1, rx_overrun=0, no uart_read pulse.
- Push 0x55, 0xA3 with a core model (tx_ready drops 1 clk after write rise, returns 100 clk later) -> uart_write rises twice, with tx_data 0x55 then 0xA3; second rise only after tx_ready returns 1; tx_empty=1 at the end.
- Push 17 bytes back-to-back while tx_ready=0 -> tx_full=1 after the 16th push; 17th ignored; exactly 16 bytes transmitted once tx_ready=1.
- Core model presents 0x3C with rx_new=1 -> exactly one uart_read pulse (1 clk); rx_empty=0 on the following cycle, cpu_rd_data=0x3C; cpu_rd_en -> rx_empty=1.
- Deliver 17 bytes with no CPU reads -> 16 stored in order, 17th dropped, rx_overrun=1; ovr_clr asserted the same cycle as a drop keeps rx_overrun=1.
- New byte 0x7E asserted the same cycle the core clears rx_new for 0x11 -> both 0x11 and 0x7E in RX FIFO in order, one uart_read pulse each; rst asserted mid-TX -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/uart_host_ctrl_if.sv
// uart_host_ctrl_if: groups the CPU-side bus and the uart-core-side handshake
// of uart_host_ctrl into one bundle.
//   slave  - the controller's view (takes CPU strobes, drives the core)
//   master - the CPU/core side (drives strobes and core status)
// With UART_HOST_IRQ_EN defined the bundle also carries the irq line.
interface uart_host_ctrl_if;
    // CPU side
    logic       cpu_wr_en;
    logic [7:0] cpu_wr_data;
    logic       cpu_rd_en;
    logic [7:0] cpu_rd_data;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_empty;
    logic       rx_overrun;
    logic       ovr_clr;
    // uart core side
    logic [7:0] uart_tx_data;
    logic       uart_write;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_new;
    logic       uart_read;
`ifdef UART_HOST_IRQ_EN
    logic       irq;

    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_rd_en, ovr_clr,
        input  uart_tx_ready, uart_rx_data, uart_rx_new,
        output cpu_rd_data, tx_full, tx_empty, rx_empty, rx_overrun,
        output uart_tx_data, uart_write, uart_read, irq
    );

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_rd_en, ovr_clr,
        output uart_tx_ready, uart_rx_data, uart_rx_new,
        input  cpu_rd_data, tx_full, tx_empty, rx_empty, rx_overrun,
        input  uart_tx_data, uart_write, uart_read, irq
    );
`else
    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_rd_en, ovr_clr,
        input  uart_tx_ready, uart_rx_data, uart_rx_new,
        output cpu_rd_data, tx_full, tx_empty, rx_empty, rx_overrun,
        output uart_tx_data, uart_write, uart_read
    );

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_rd_en, ovr_clr,
        output uart_tx_ready, uart_rx_data, uart_rx_new,
        input  cpu_rd_data, tx_full, tx_empty, rx_empty, rx_overrun,
        input  uart_tx_data, uart_write, uart_read
    );
`endif
endinterface

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: host-side controller for the uart core.
// CPU writes are buffered in a TX FIFO and handed to the core one byte per
// write/tx_ready handshake; bytes flagged by the core's rx_new are drained
// into an RX FIFO with a fixed 3-cycle accept (read pulse, then two cycles
// of not looking at rx_new while the core's clear propagates).
// Optional feature macro: UART_HOST_IRQ_EN (adds the registered irq output).
module uart_host_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic             clk,
    input logic             rst,
    uart_host_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_STROBE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACK,
        RX_GAP
    } rx_state_t;

    function automatic logic ptr_empty(input ptr_t w, input ptr_t r);
        return w == r;
    endfunction

    // Same slot index, opposite wrap bit.
    function automatic logic ptr_full(input ptr_t w, input ptr_t r);
        return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
    endfunction

    // ------------------------------------------------------------ TX side
    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wp, tx_rp, tx_wp_nxt, tx_rp_nxt;
    tx_state_t  tx_state;
    logic       tx_fifo_empty, tx_fifo_full;
    logic       tx_launch, tx_done, tx_push, tx_pop, tx_idle_nxt;

    always_comb begin
        tx_fifo_empty = ptr_empty(tx_wp, tx_rp);
        tx_fifo_full  = ptr_full(tx_wp, tx_rp);
        tx_launch     = (tx_state == TX_IDLE) && !tx_fifo_empty && bus.uart_tx_ready;
        tx_done       = (tx_state == TX_WAIT_DONE) && bus.uart_tx_ready;
        tx_pop        = tx_launch;
        // A pop in the same cycle frees the slot a full FIFO would refuse.
        tx_push       = bus.cpu_wr_en && (!tx_fifo_full || tx_pop);
        tx_wp_nxt     = tx_wp + ptr_t'(tx_push);
        tx_rp_nxt     = tx_rp + ptr_t'(tx_pop);
        tx_idle_nxt   = ((tx_state == TX_IDLE) && !tx_launch) || tx_done;
    end

    // TX storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp[PW-2:0]] <= bus.cpu_wr_data;
        end
    end

    // TX pointers and registered full/empty flags (empty also covers the in-flight byte).
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp        <= '0;
            tx_rp        <= '0;
            bus.tx_full  <= 1'b0;
            bus.tx_empty <= 1'b1;
        end else begin
            tx_wp        <= tx_wp_nxt;
            tx_rp        <= tx_rp_nxt;
            bus.tx_full  <= ptr_full(tx_wp_nxt, tx_rp_nxt);
            bus.tx_empty <= ptr_empty(tx_wp_nxt, tx_rp_nxt) && tx_idle_nxt;
        end
    end

    // TX FSM: two-cycle write strobe, then follow tx_ready low and back high.
    // After a reset it simply waits in IDLE for tx_ready, which re-syncs with
    // a core still finishing an abandoned byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state         <= TX_IDLE;
            bus.uart_write   <= 1'b0;
            bus.uart_tx_data <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_launch) begin
                        bus.uart_tx_data <= tx_mem[tx_rp[PW-2:0]];
                        bus.uart_write   <= 1'b1;
                        tx_state         <= TX_STROBE;
                    end
                end
                TX_STROBE: begin
                    tx_state <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    bus.uart_write <= 1'b0;
                    if (!bus.uart_tx_ready) begin
                        tx_state <= TX_WAIT_DONE;
                    end
                end
                TX_WAIT_DONE: begin
                    if (bus.uart_tx_ready) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ RX side
    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wp, rx_rp, rx_wp_nxt, rx_rp_nxt;
    rx_state_t  rx_state;
    logic       rx_fifo_empty, rx_fifo_full;
    logic       rx_accept, rx_push, rx_pop, rx_drop, rx_head_load;

    always_comb begin
        rx_fifo_empty = ptr_empty(rx_wp, rx_rp);
        rx_fifo_full  = ptr_full(rx_wp, rx_rp);
        rx_accept     = (rx_state == RX_IDLE) && bus.uart_rx_new;
        rx_pop        = bus.cpu_rd_en && !rx_fifo_empty;
        rx_push       = rx_accept && (!rx_fifo_full || rx_pop);
        rx_drop       = rx_accept && rx_fifo_full && !rx_pop;
        rx_wp_nxt     = rx_wp + ptr_t'(rx_push);
        rx_rp_nxt     = rx_rp + ptr_t'(rx_pop);
        // The visible head changes on a pop or when the first byte lands.
        rx_head_load  = rx_pop || (rx_push && rx_fifo_empty);
    end

    // RX storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp[PW-2:0]] <= bus.uart_rx_data;
        end
    end

    // RX pointers, registered head/empty, and the sticky overrun (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp           <= '0;
            rx_rp           <= '0;
            bus.rx_empty    <= 1'b1;
            bus.cpu_rd_data <= 8'h00;
            bus.rx_overrun  <= 1'b0;
        end else begin
            rx_wp        <= rx_wp_nxt;
            rx_rp        <= rx_rp_nxt;
            bus.rx_empty <= ptr_empty(rx_wp_nxt, rx_rp_nxt);
            if (rx_head_load) begin
                // New head may be the byte being written this very cycle.
                bus.cpu_rd_data <= (rx_push && (rx_rp_nxt == rx_wp))
                                   ? bus.uart_rx_data
                                   : rx_mem[rx_rp_nxt[PW-2:0]];
            end
            if (rx_drop) begin
                bus.rx_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                bus.rx_overrun <= 1'b0;
            end
        end
    end

    // RX FSM: one-cycle read pulse, then a blind GAP cycle before rx_new is looked at again.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            bus.uart_read <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (bus.uart_rx_new) begin
                        bus.uart_read <= 1'b1;
                        rx_state      <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    bus.uart_read <= 1'b0;
                    rx_state      <= RX_GAP;
                end
                RX_GAP: begin
                    rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_HOST_IRQ_EN
    logic tx_empty_q;
    logic tx_rise_sticky;

    // Interrupt: RX data pending, overrun, or TX drained since the last CPU write.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_empty_q     <= 1'b1;
            tx_rise_sticky <= 1'b0;
            bus.irq        <= 1'b0;
        end else begin
            tx_empty_q <= bus.tx_empty;
            if (bus.tx_empty && !tx_empty_q) begin
                tx_rise_sticky <= 1'b1;
            end else if (bus.cpu_wr_en) begin
                tx_rise_sticky <= 1'b0;
            end
            bus.irq <= !bus.rx_empty || bus.rx_overrun || tx_rise_sticky;
        end
    end
`else
    // No interrupt logic in this build.
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: a small uart-core model on the far side, a
// queue-based reference of both FIFOs checked every cycle, a table of
// fill vectors, directed corner sequences and a randomized phase.
module tb_uart_host_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_host_ctrl_if bus ();

    uart_host_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- uart core model
    logic       core_ready = 1'b1;
    int         busy       = 0;
    logic       wr_prev    = 1'b0;
    int         tx_time    = 100;
    bit         hold_ready = 1'b0;
    logic       rx_new_r   = 1'b0;
    logic [7:0] rx_data_r  = 8'h00;
    logic       rd_prev    = 1'b0;
    logic [7:0] rx_src[$];

    assign bus.uart_tx_ready = core_ready && !hold_ready;
    assign bus.uart_rx_new   = rx_new_r;
    assign bus.uart_rx_data  = rx_data_r;

    always @(posedge clk) begin
        wr_prev <= bus.uart_write;
        if (bus.uart_write && !wr_prev) begin
            core_ready <= 1'b0;
            busy       <= tx_time;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) core_ready <= 1'b1;
        end
        rd_prev <= bus.uart_read;
        if ((!rx_new_r || (bus.uart_read && !rd_prev)) && rx_src.size() != 0) begin
            rx_new_r  <= 1'b1;
            rx_data_r <= rx_src.pop_front();
        end else if (bus.uart_read && !rd_prev) begin
            rx_new_r <= 1'b0;
        end
    end

    // ---------------- reference model state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_inj[$];
    logic [7:0] tx_obs[$];
    int         rise_cyc[$];
    int         acc_idx, read_rises, cyc;
    bit         ovr_m;
    logic       w_last, r_last;
    int         errors, checks;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic inject(input logic [7:0] b);
        rx_src.push_back(b);
        rx_inj.push_back(b);
    endtask

    // One clock: advance the reference by what happened at the edge, then compare.
    task automatic tick();
        logic       rise_w, rise_r, pop, ok, in_rng;
        logic [7:0] b;
        @(posedge clk);
        #1;
        cyc++;
        rise_w = bus.uart_write && !w_last;
        rise_r = bus.uart_read && !r_last;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            ovr_m = 1'b0;
            chk1("rst_uart_write", bus.uart_write, 1'b0);
            chk1("rst_uart_read", bus.uart_read, 1'b0);
            chk8("rst_uart_tx_data", bus.uart_tx_data, 8'h00);
            chk8("rst_cpu_rd_data", bus.cpu_rd_data, 8'h00);
            chk1("rst_tx_empty", bus.tx_empty, 1'b1);
        end else begin
            chk1("read_pulse_width", bus.uart_read && r_last, 1'b0);
            if (rise_w) begin
                chk1("tx_launch_has_data", tx_q.size() != 0, 1'b1);
                chk1("tx_ready_at_launch", core_ready, 1'b1);
                chk1("tx_empty_inflight", bus.tx_empty, 1'b0);
                if (tx_q.size() != 0) chk8("tx_data", bus.uart_tx_data, tx_q[0]);
                tx_obs.push_back(bus.uart_tx_data);
                rise_cyc.push_back(cyc);
            end
            ok = (tx_q.size() < 16) || rise_w;
            if (rise_w && tx_q.size() != 0) void'(tx_q.pop_front());
            if (bus.cpu_wr_en && ok) tx_q.push_back(bus.cpu_wr_data);

            pop    = bus.cpu_rd_en && (rx_q.size() != 0);
            ok     = (rx_q.size() < 16) || pop;
            in_rng = acc_idx < rx_inj.size();
            b      = 8'h00;
            if (rise_r) begin
                read_rises++;
                chk1("rx_accept_in_range", in_rng, 1'b1);
                if (in_rng) begin
                    b = rx_inj[acc_idx];
                    chk8("rx_core_data", bus.uart_rx_data, b);
                    acc_idx++;
                end
            end
            if (pop) void'(rx_q.pop_front());
            if (rise_r && in_rng && ok) rx_q.push_back(b);
            if (rise_r && in_rng && !ok) ovr_m = 1'b1;
            else if (bus.ovr_clr) ovr_m = 1'b0;
        end
        chk1("tx_full", bus.tx_full, tx_q.size() == 16);
        if (tx_q.size() != 0) chk1("tx_empty_pending", bus.tx_empty, 1'b0);
        chk1("rx_empty", bus.rx_empty, rx_q.size() == 0);
        if (rx_q.size() != 0) chk8("cpu_rd_data", bus.cpu_rd_data, rx_q[0]);
        chk1("rx_overrun", bus.rx_overrun, ovr_m);
        w_last = bus.uart_write;
        r_last = bus.uart_read;
    endtask

    task automatic push(input logic [7:0] b);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_data = b;
        tick();
        bus.cpu_wr_en = 1'b0;
    endtask

    task automatic rd();
        bus.cpu_rd_en = 1'b1;
        tick();
        bus.cpu_rd_en = 1'b0;
    endtask

    // Wait for n transmissions to have started and everything to settle.
    task automatic wait_tx(input int n, input int bound, input string name);
        int i;
        for (i = 0; i < bound; i++) begin
            if (tx_obs.size() >= n && bus.tx_empty && bus.uart_tx_ready) break;
            tick();
        end
        chk1(name, i < bound, 1'b1);
    endtask

    task automatic wait_rx(input int n_acc, input int bound, input string name);
        int i;
        for (i = 0; i < bound; i++) begin
            if (acc_idx >= n_acc && rx_src.size() == 0) break;
            tick();
        end
        chk1(name, i < bound, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int base, rr, base_acc, i;
        for (int k = 0; k < 17; k++) begin
            vecs[k].data      = 8'(k * 13 + 7);
            vecs[k].exp_full  = (k >= 15);
            vecs[k].exp_empty = 1'b0;
        end
        errors = 0; checks = 0; cyc = 0; acc_idx = 0; read_rises = 0;
        ovr_m = 1'b0; w_last = 1'b0; r_last = 1'b0;
        rst = 1'b1;
        bus.cpu_wr_en = 1'b0; bus.cpu_wr_data = 8'h00;
        bus.cpu_rd_en = 1'b0; bus.ovr_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Idle after reset
        repeat (10) tick();
        chkn("idle_no_read", read_rises, 0);
        chkn("idle_no_write", tx_obs.size(), 0);
        chk1("idle_tx_empty", bus.tx_empty, 1'b1);
`ifdef UART_HOST_IRQ_EN
        chk1("idle_irq", bus.irq, 1'b0);
`endif

        // Two bytes through a slow core
        tx_time = 100;
        push(8'h55);
        push(8'hA3);
        wait_tx(2, 600, "tx2_timeout");
        chkn("tx2_count", tx_obs.size(), 2);
        if (tx_obs.size() >= 2) begin
            chk8("tx2_first", tx_obs[0], 8'h55);
            chk8("tx2_second", tx_obs[1], 8'hA3);
            chk1("tx2_gap", (rise_cyc[1] - rise_cyc[0]) > tx_time, 1'b1);
        end
        chk1("tx2_empty_end", bus.tx_empty, 1'b1);

        // Table: fill 17 with tx_ready held low
        hold_ready = 1'b1;
        tx_time    = 8;
        base       = tx_obs.size();
        for (int k = 0; k < 17; k++) begin
            bus.cpu_wr_en   = 1'b1;
            bus.cpu_wr_data = vecs[k].data;
            tick();
            chk1("vec_tx_full", bus.tx_full, vecs[k].exp_full);
            chk1("vec_tx_empty", bus.tx_empty, vecs[k].exp_empty);
        end
        bus.cpu_wr_en = 1'b0;
        tick();
        chkn("vec_no_tx_while_busy", tx_obs.size(), base);
        hold_ready = 1'b0;
        wait_tx(base + 16, 1500, "vec_tx_timeout");
        repeat (30) tick();
        chkn("vec_tx_count", tx_obs.size(), base + 16);
        for (int k = 0; k < 16; k++)
            if (base + k < tx_obs.size()) chk8("vec_tx_data", tx_obs[base + k], vecs[k].data);

        // Single received byte
        rr = read_rises;
        inject(8'h3C);
        for (i = 0; i < 30 && bus.rx_empty; i++) tick();
        chk1("rx1_nonempty", bus.rx_empty, 1'b0);
        chk8("rx1_data", bus.cpu_rd_data, 8'h3C);
        repeat (5) tick();
        chkn("rx1_one_read", read_rises - rr, 1);
        rd();
        chk1("rx1_empty_after_pop", bus.rx_empty, 1'b1);

        // 17 bytes with no reads: 16 kept, one dropped
        base_acc = acc_idx;
        for (int k = 0; k < 17; k++) inject(8'(8'hC0 + k));
        wait_rx(base_acc + 17, 300, "rx17_timeout");
        repeat (5) tick();
        chk1("rx17_overrun", bus.rx_overrun, 1'b1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk1("rx17_ovr_cleared", bus.rx_overrun, 1'b0);
        // Drop with clear held: set must win
        rr = read_rises;
        bus.ovr_clr = 1'b1;
        inject(8'hEE);
        for (i = 0; i < 30 && read_rises == rr; i++) tick();
        chk1("ovr_set_wins", bus.rx_overrun, 1'b1);
        bus.ovr_clr = 1'b0;
        tick();
        chk1("ovr_sticky", bus.rx_overrun, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk8("rx17_data", bus.cpu_rd_data, 8'(8'hC0 + k));
            rd();
        end
        chk1("rx17_drained", bus.rx_empty, 1'b1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;

        // Next byte arrives on the same edge the core clears rx_new
        rr = read_rises;
        inject(8'h11);
        inject(8'h7E);
        wait_rx(acc_idx + 2, 60, "rxsc_timeout");
        repeat (4) tick();
        chkn("rxsc_reads", read_rises - rr, 2);
        chk8("rxsc_first", bus.cpu_rd_data, 8'h11);
        rd();
        chk8("rxsc_second", bus.cpu_rd_data, 8'h7E);
        rd();
        chk1("rxsc_empty", bus.rx_empty, 1'b1);

        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            bus.cpu_wr_en   = ($urandom % 4) == 0;
            bus.cpu_wr_data = 8'($urandom);
            bus.cpu_rd_en   = ($urandom % 3) == 0;
            bus.ovr_clr     = ($urandom % 16) == 0;
            if (($urandom % 5) == 0) inject(8'($urandom));
            if (($urandom % 200) == 0) tx_time = $urandom_range(3, 20);
            tick();
        end
        bus.cpu_wr_en = 1'b0; bus.cpu_rd_en = 1'b0; bus.ovr_clr = 1'b0;
        wait_rx(rx_inj.size(), 400, "rand_rx_drain");
        wait_tx(0, 2000, "rand_tx_drain");
        chkn("rand_rx_all_accepted", acc_idx, rx_inj.size());
        for (i = 0; i < 20 && !bus.rx_empty; i++) rd();

        // Reset in the middle of a transmission
        tx_time = 40;
        base = tx_obs.size();
        push(8'h5A);
        for (i = 0; i < 50 && tx_obs.size() == base; i++) tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk1("rst_mid_tx_rx_overrun", bus.rx_overrun, 1'b0);
        rst = 1'b0;
        push(8'h96);
        wait_tx(base + 2, 400, "post_rst_tx_timeout");
        chkn("post_rst_tx_count", tx_obs.size(), base + 2);
        if (tx_obs.size() == base + 2) chk8("post_rst_tx_data", tx_obs[base + 1], 8'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
